// File: rtl/parc_core_scoreboard_spec.sv
// In-order-issue scoreboard for the PARC decode stage: tracks pending destinations,
// drives operand bypass selects, RAW/writeback-port stalls and squashes speculative entries.
module parc_core_scoreboard_spec #(
  parameter int NREGS   = 32,
  parameter int LAT_W   = 6,
  parameter int NFU     = 3,
  parameter int ROB_W   = 4,
  parameter int BYP_LIM = 3,
  localparam int AREG_W = $clog2(NREGS),
  localparam int FU_W   = $clog2(NFU + 3)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [AREG_W-1:0] src0,
  input  logic              src0_en,
  input  logic [AREG_W-1:0] src1,
  input  logic              src1_en,
  input  logic [AREG_W-1:0] dst,
  input  logic              dst_en,
  input  logic [FU_W-1:0]   func_unit,
  input  logic [LAT_W-1:0]  latency,
  input  logic              inst_val_Dhl,
  input  logic              non_sb_stall_Dhl,
  input  logic [LAT_W-1:0]  stalls,
  input  logic [ROB_W-1:0]  rob_alloc_slot,
  input  logic              rob_commit_wen,
  input  logic [ROB_W-1:0]  rob_commit_slot,
  input  logic              spec_Dhl,
  input  logic              br_resolve,
  input  logic              br_mispred,
  output logic [FU_W-1:0]   src0_byp_mux_sel,
  output logic [ROB_W-1:0]  src0_byp_rob_slot,
  output logic [FU_W-1:0]   src1_byp_mux_sel,
  output logic [ROB_W-1:0]  src1_byp_rob_slot,
  output logic              stall_hazard,
  output logic [FU_W-1:0]   wb_mux_sel
);

  logic [NREGS-1:0] pending_r;
  logic [NREGS-1:0] spec_r;
  logic [LAT_W-1:0] lat_r   [NREGS];
  logic [FU_W-1:0]  fu_r    [NREGS];
  logic [ROB_W-1:0] rob_r   [NREGS];
  logic [LAT_W-1:0] wbvec_r [NFU];

  logic            wb_hazard_s;
  logic [FU_W-1:0] wb_sel_s;
  logic            src0_ok_s;
  logic            src1_ok_s;
  logic            accept_s;
  logic            alloc_s;
  logic            squash_s;

  function automatic logic src_ok_f(input logic en, input logic [AREG_W-1:0] src,
                                    input logic pend, input logic [LAT_W-1:0] lat);
    return !en || (src == AREG_W'(0)) || !pend || (32'(lat) < (32'd1 << BYP_LIM));
  endfunction

  // A producer with one cycle left is caught on the writeback bus; zero means it sits in the ROB.
  function automatic logic [FU_W-1:0] byp_sel_f(input logic [AREG_W-1:0] src, input logic pend,
                                                input logic [LAT_W-1:0] lat,
                                                input logic [FU_W-1:0] fu);
    logic [FU_W-1:0] sel;
    if ((src == AREG_W'(0)) || !pend) begin
      sel = FU_W'(0);
    end else if (lat == LAT_W'(1)) begin
      sel = FU_W'(NFU + 1);
    end else if (lat == LAT_W'(0)) begin
      sel = FU_W'(NFU + 2);
    end else begin
      sel = fu;
    end
    return sel;
  endfunction

  // Hazard detection, issue acceptance and writeback port selection
  always_comb begin
    wb_hazard_s = 1'b0;
    wb_sel_s    = FU_W'(0);
    for (int f = NFU - 1; f >= 0; f--) begin
      wb_hazard_s = wb_hazard_s | (|((wbvec_r[f] >> 1) & latency));
      wb_sel_s    = wbvec_r[f][1] ? FU_W'(f + 1) : wb_sel_s;
    end
    squash_s  = br_resolve && br_mispred;
    src0_ok_s = src_ok_f(src0_en, src0, pending_r[src0], lat_r[src0]);
    src1_ok_s = src_ok_f(src1_en, src1, pending_r[src1], lat_r[src1]);
    accept_s  = src0_ok_s && src1_ok_s && !wb_hazard_s && inst_val_Dhl &&
                !non_sb_stall_Dhl && !squash_s;
    alloc_s   = accept_s && dst_en && (dst != AREG_W'(0));
  end

  assign src0_byp_mux_sel  = byp_sel_f(src0, pending_r[src0], lat_r[src0], fu_r[src0]);
  assign src1_byp_mux_sel  = byp_sel_f(src1, pending_r[src1], lat_r[src1], fu_r[src1]);
  assign src0_byp_rob_slot = rob_r[src0];
  assign src1_byp_rob_slot = rob_r[src1];
  assign stall_hazard      = !accept_s;
  assign wb_mux_sel        = wb_sel_s;

  // Per-register tracking; a new producer overrides a same-cycle commit of its old slot
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_r <= '0;
      spec_r    <= '0;
      for (int r = 0; r < NREGS; r++) begin
        lat_r[r] <= LAT_W'(0);
        fu_r[r]  <= FU_W'(0);
      end
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        if (alloc_s && (dst == AREG_W'(r))) begin
          pending_r[r] <= 1'b1;
          lat_r[r]     <= latency;
          fu_r[r]      <= func_unit;
          spec_r[r]    <= spec_Dhl;
        end else if (squash_s && spec_r[r]) begin
          pending_r[r] <= 1'b0;
          lat_r[r]     <= LAT_W'(0);
          fu_r[r]      <= FU_W'(0);
          spec_r[r]    <= 1'b0;
        end else begin
          lat_r[r] <= (lat_r[r] & stalls) | ((lat_r[r] & ~stalls) >> 1);
          if (rob_commit_wen && (rob_commit_slot == rob_r[r])) begin
            pending_r[r] <= 1'b0;
          end
          if (br_resolve && !br_mispred) begin
            spec_r[r] <= 1'b0;
          end
        end
      end
    end
  end

  // ROB slot per register; left unreset because pending masks any stale value
  always_ff @(posedge clk) begin
    for (int r = 0; r < NREGS; r++) begin
      if (alloc_s && (dst == AREG_W'(r))) begin
        rob_r[r] <= rob_alloc_slot;
      end
    end
  end

  // Writeback port occupancy; squashed producers keep their slot as bubbles
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int f = 0; f < NFU; f++) begin
        wbvec_r[f] <= LAT_W'(0);
      end
    end else begin
      for (int f = 0; f < NFU; f++) begin
        wbvec_r[f] <= (wbvec_r[f] >> 1) |
                      ((accept_s && (func_unit == FU_W'(f + 1))) ? latency : LAT_W'(0));
      end
    end
  end

endmodule

// File: tb/tb_parc_core_scoreboard_spec.sv
// Bench for parc_core_scoreboard_spec: directed table, corner sequences, and random
// stimulus against a schedule-based reference model.
module tb_parc_core_scoreboard_spec;
  localparam int NFU = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] src0, src1, dst;
  logic       src0_en, src1_en, dst_en;
  logic [2:0] func_unit;
  logic [5:0] latency, stalls;
  logic       inst_val_Dhl, non_sb_stall_Dhl;
  logic [3:0] rob_alloc_slot, rob_commit_slot;
  logic       rob_commit_wen, spec_Dhl, br_resolve, br_mispred;
  logic [2:0] src0_byp_mux_sel, src1_byp_mux_sel, wb_mux_sel;
  logic [3:0] src0_byp_rob_slot, src1_byp_rob_slot;
  logic       stall_hazard;

  int n_checks = 0;
  int n_fail   = 0;

  parc_core_scoreboard_spec dut (
    .clk(clk), .reset(reset),
    .src0(src0), .src0_en(src0_en), .src1(src1), .src1_en(src1_en),
    .dst(dst), .dst_en(dst_en), .func_unit(func_unit), .latency(latency),
    .inst_val_Dhl(inst_val_Dhl), .non_sb_stall_Dhl(non_sb_stall_Dhl), .stalls(stalls),
    .rob_alloc_slot(rob_alloc_slot), .rob_commit_wen(rob_commit_wen),
    .rob_commit_slot(rob_commit_slot), .spec_Dhl(spec_Dhl),
    .br_resolve(br_resolve), .br_mispred(br_mispred),
    .src0_byp_mux_sel(src0_byp_mux_sel), .src0_byp_rob_slot(src0_byp_rob_slot),
    .src1_byp_mux_sel(src1_byp_mux_sel), .src1_byp_rob_slot(src1_byp_rob_slot),
    .stall_hazard(stall_hazard), .wb_mux_sel(wb_mux_sel)
  );

  always #5 clk = ~clk;

  // Reference model: remaining cycles per register (-1 = waiting in ROB) and,
  // per FU, the absolute cycles at which its writebacks land.
  bit m_pend[32];
  int m_rem[32];
  int m_fu[32];
  int m_rob[32];
  bit m_spec[32];
  int m_wb[NFU][$];
  int m_cyc;

  function automatic int lat_idx(input logic [5:0] l);
    int k = -1;
    for (int i = 0; i < 6; i++) if (l[i]) k = i;
    return k;
  endfunction

  function automatic void m_reset();
    for (int r = 0; r < 32; r++) begin
      m_pend[r] = 1'b0; m_rem[r] = -1; m_fu[r] = 0; m_spec[r] = 1'b0;
    end
    for (int f = 0; f < NFU; f++) m_wb[f].delete();
    m_cyc = 0;
  endfunction

  function automatic bit m_src_ok(input logic en, input logic [4:0] s);
    return !en || s == 5'd0 || !m_pend[s] || m_rem[s] < 3;
  endfunction

  function automatic bit m_wb_haz();
    int k = lat_idx(latency);
    if (k < 0) return 1'b0;
    for (int f = 0; f < NFU; f++)
      for (int i = 0; i < m_wb[f].size(); i++)
        if (m_wb[f][i] == m_cyc + k + 1) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_accept();
    return m_src_ok(src0_en, src0) && m_src_ok(src1_en, src1) && !m_wb_haz() &&
           inst_val_Dhl && !non_sb_stall_Dhl && !(br_resolve && br_mispred);
  endfunction

  function automatic int m_sel(input logic [4:0] s);
    if (s == 5'd0 || !m_pend[s]) return 0;
    if (m_rem[s] == 0) return NFU + 1;
    if (m_rem[s] < 0) return NFU + 2;
    return m_fu[s];
  endfunction

  function automatic int m_wbsel();
    for (int f = 0; f < NFU; f++)
      for (int i = 0; i < m_wb[f].size(); i++)
        if (m_wb[f][i] == m_cyc + 1) return f + 1;
    return 0;
  endfunction

  function automatic void m_update();
    bit acc = m_accept();
    int k = lat_idx(latency);
    for (int r = 0; r < 32; r++) begin
      if (acc && dst_en && dst != 5'd0 && int'(dst) == r) begin
        m_pend[r] = 1'b1; m_rem[r] = k; m_fu[r] = int'(func_unit);
        m_rob[r] = int'(rob_alloc_slot); m_spec[r] = spec_Dhl;
      end else if (br_resolve && br_mispred && m_spec[r]) begin
        m_pend[r] = 1'b0; m_rem[r] = -1; m_fu[r] = 0; m_spec[r] = 1'b0;
      end else begin
        if (m_rem[r] >= 0 && !stalls[m_rem[r]]) m_rem[r] = m_rem[r] - 1;
        if (rob_commit_wen && int'(rob_commit_slot) == m_rob[r]) m_pend[r] = 1'b0;
        if (br_resolve && !br_mispred) m_spec[r] = 1'b0;
      end
    end
    for (int f = 0; f < NFU; f++)
      if (acc && int'(func_unit) == f + 1 && k >= 0) m_wb[f].push_back(m_cyc + k + 1);
    m_cyc++;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic idle();
    src0 = 5'd0; src1 = 5'd0; src0_en = 1'b1; src1_en = 1'b1;
    dst = 5'd0; dst_en = 1'b0; func_unit = 3'd0; latency = 6'd0; stalls = 6'd0;
    inst_val_Dhl = 1'b1; non_sb_stall_Dhl = 1'b0; rob_alloc_slot = 4'd0;
    rob_commit_wen = 1'b0; rob_commit_slot = 4'd0; spec_Dhl = 1'b0;
    br_resolve = 1'b0; br_mispred = 1'b0;
  endtask

  task automatic issue(input logic [4:0] d, input logic [2:0] fu, input logic [5:0] l,
                       input logic [3:0] slot);
    dst = d; dst_en = 1'b1; func_unit = fu; latency = l; rob_alloc_slot = slot;
  endtask

  task automatic advance();
    @(posedge clk);
    m_update();
    #1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  typedef struct {
    logic [4:0] src0, src1, dst;
    logic       den;
    logic [2:0] fu;
    logic [5:0] lat;
    logic       val;
    logic       exp_stall;
    logic [2:0] exp_s0, exp_s1, exp_wb;
  } vec_t;

  vec_t tbl[11];

  initial begin
    tbl[0]  = '{5'd0, 5'd0,  5'd5,  1'b1, 3'd1, 6'b000100, 1'b1, 1'b0, 3'd0, 3'd0, 3'd0};
    tbl[1]  = '{5'd5, 5'd0,  5'd10, 1'b1, 3'd2, 6'b000010, 1'b1, 1'b1, 3'd1, 3'd0, 3'd0};
    tbl[2]  = '{5'd5, 5'd0,  5'd10, 1'b1, 3'd2, 6'b000100, 1'b1, 1'b0, 3'd1, 3'd0, 3'd1};
    tbl[3]  = '{5'd5, 5'd10, 5'd0,  1'b0, 3'd0, 6'b000000, 1'b1, 1'b0, 3'd4, 3'd2, 3'd0};
    tbl[4]  = '{5'd5, 5'd10, 5'd0,  1'b0, 3'd0, 6'b000000, 1'b1, 1'b0, 3'd5, 3'd2, 3'd2};
    tbl[5]  = '{5'd5, 5'd10, 5'd7,  1'b1, 3'd3, 6'b100000, 1'b1, 1'b0, 3'd5, 3'd4, 3'd0};
    tbl[6]  = '{5'd0, 5'd7,  5'd0,  1'b0, 3'd0, 6'b000000, 1'b1, 1'b1, 3'd0, 3'd3, 3'd0};
    tbl[7]  = '{5'd0, 5'd7,  5'd0,  1'b0, 3'd0, 6'b000000, 1'b1, 1'b1, 3'd0, 3'd3, 3'd0};
    tbl[8]  = '{5'd0, 5'd7,  5'd0,  1'b0, 3'd0, 6'b000000, 1'b1, 1'b1, 3'd0, 3'd3, 3'd0};
    tbl[9]  = '{5'd0, 5'd7,  5'd0,  1'b0, 3'd0, 6'b000000, 1'b1, 1'b0, 3'd0, 3'd3, 3'd0};
    tbl[10] = '{5'd0, 5'd0,  5'd0,  1'b0, 3'd0, 6'b000000, 1'b0, 1'b1, 3'd0, 3'd0, 3'd3};

    idle();
    m_reset();
    #2;
    chk("reset_s0sel", int'(src0_byp_mux_sel), 0);
    chk("reset_wbsel", int'(wb_mux_sel), 0);
    chk("reset_stall", int'(stall_hazard), 0);
    do_reset();

    // Directed table: bypass progression, writeback-port conflict, long-latency RAW stall
    for (int i = 0; i < 11; i++) begin
      idle();
      src0 = tbl[i].src0; src1 = tbl[i].src1; dst = tbl[i].dst; dst_en = tbl[i].den;
      func_unit = tbl[i].fu; latency = tbl[i].lat; inst_val_Dhl = tbl[i].val;
      rob_alloc_slot = tbl[i].dst[3:0];
      #3;
      chk($sformatf("tbl%0d_stall", i), int'(stall_hazard), int'(tbl[i].exp_stall));
      chk($sformatf("tbl%0d_s0sel", i), int'(src0_byp_mux_sel), int'(tbl[i].exp_s0));
      chk($sformatf("tbl%0d_s1sel", i), int'(src1_byp_mux_sel), int'(tbl[i].exp_s1));
      chk($sformatf("tbl%0d_wbsel", i), int'(wb_mux_sel), int'(tbl[i].exp_wb));
      advance();
    end

    // Speculative squash leaves the non-speculative producer alone
    do_reset();
    idle(); issue(5'd3, 3'd1, 6'b000010, 4'd1); advance();
    idle(); issue(5'd9, 3'd2, 6'b001000, 4'd4); spec_Dhl = 1'b1; advance();
    idle(); src0 = 5'd9; src1 = 5'd3; br_resolve = 1'b1; br_mispred = 1'b1; #3;
    chk("sq_stall", int'(stall_hazard), 1);
    chk("sq_pre_s0sel", int'(src0_byp_mux_sel), 2);
    chk("sq_pre_s1sel", int'(src1_byp_mux_sel), 4);
    chk("sq_pre_rob0", int'(src0_byp_rob_slot), 4);
    advance();
    idle(); src0 = 5'd9; src1 = 5'd3; #3;
    chk("sq_post_s0sel", int'(src0_byp_mux_sel), 0);
    chk("sq_post_s1sel", int'(src1_byp_mux_sel), 5);
    chk("sq_post_rob1", int'(src1_byp_rob_slot), 1);
    chk("sq_post_stall", int'(stall_hazard), 0);
    advance();

    // Accept and commit of the old slot in the same cycle: new producer wins
    do_reset();
    idle(); issue(5'd4, 3'd1, 6'b000001, 4'd2); advance();
    idle(); src0 = 5'd4; issue(5'd4, 3'd2, 6'b000100, 4'd7);
    rob_commit_wen = 1'b1; rob_commit_slot = 4'd2; #3;
    chk("cm_s0sel_old", int'(src0_byp_mux_sel), 4);
    chk("cm_accept", int'(stall_hazard), 0);
    advance();
    idle(); src0 = 5'd4; rob_commit_wen = 1'b1; rob_commit_slot = 4'd2; #3;
    chk("cm_s0sel_new", int'(src0_byp_mux_sel), 2);
    chk("cm_rob_new", int'(src0_byp_rob_slot), 7);
    advance();
    idle(); src0 = 5'd4; rob_commit_wen = 1'b1; rob_commit_slot = 4'd7; #3;
    chk("cm_stale_commit", int'(src0_byp_mux_sel), 2);
    advance();
    idle(); src0 = 5'd4; #3;
    chk("cm_committed", int'(src0_byp_mux_sel), 0);
    advance();

    // Stage stall freezes latency, then asynchronous reset mid-run
    do_reset();
    idle(); issue(5'd6, 3'd1, 6'b000100, 4'd0); advance();
    idle(); src0 = 5'd6; stalls = 6'b000100; #3;
    chk("fz_c1", int'(src0_byp_mux_sel), 1); advance();
    idle(); src0 = 5'd6; stalls = 6'b000100; #3;
    chk("fz_c2", int'(src0_byp_mux_sel), 1); advance();
    idle(); src0 = 5'd6; #3;
    chk("fz_c3", int'(src0_byp_mux_sel), 1); advance();
    idle(); src0 = 5'd6; issue(5'd8, 3'd2, 6'b000010, 4'd3); #3;
    chk("fz_c4", int'(src0_byp_mux_sel), 1);
    chk("fz_c4_stall", int'(stall_hazard), 0); advance();
    idle(); src0 = 5'd6; src1 = 5'd8; inst_val_Dhl = 1'b0; #3;
    chk("fz_c5_s0", int'(src0_byp_mux_sel), 4);
    chk("fz_c5_s1", int'(src1_byp_mux_sel), 2);
    chk("fz_c5_wb", int'(wb_mux_sel), 2);
    reset = 1'b1; #1;
    chk("rst_mid_s0", int'(src0_byp_mux_sel), 0);
    chk("rst_mid_s1", int'(src1_byp_mux_sel), 0);
    chk("rst_mid_wb", int'(wb_mux_sel), 0);
    chk("rst_mid_stall", int'(stall_hazard), 1);
    m_reset();
    @(posedge clk); #1; reset = 1'b0;

    // Random traffic over a small register window against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      src0 = 5'($urandom_range(0, 7)); src1 = 5'($urandom_range(0, 7));
      src0_en = ($urandom_range(0, 3) != 0); src1_en = ($urandom_range(0, 3) != 0);
      dst = 5'($urandom_range(0, 7)); dst_en = ($urandom_range(0, 3) != 0);
      func_unit = 3'($urandom_range(1, 3));
      latency = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'(32'd1 << $urandom_range(0, 5));
      inst_val_Dhl = ($urandom_range(0, 7) != 0); non_sb_stall_Dhl = ($urandom_range(0, 7) == 0);
      stalls = 6'($urandom & $urandom & $urandom);
      rob_alloc_slot = 4'($urandom_range(0, 15));
      rob_commit_wen = ($urandom_range(0, 2) == 0); rob_commit_slot = 4'($urandom_range(0, 15));
      spec_Dhl = ($urandom_range(0, 3) == 0);
      br_resolve = ($urandom_range(0, 7) == 0); br_mispred = ($urandom_range(0, 1) == 1);
      #3;
      chk("rnd_stall", int'(stall_hazard), int'(!m_accept()));
      chk("rnd_s0sel", int'(src0_byp_mux_sel), m_sel(src0));
      chk("rnd_s1sel", int'(src1_byp_mux_sel), m_sel(src1));
      chk("rnd_wbsel", int'(wb_mux_sel), m_wbsel());
      if (src0 != 5'd0 && m_pend[src0]) chk("rnd_rob0", int'(src0_byp_rob_slot), m_rob[src0]);
      if (src1 != 5'd0 && m_pend[src1]) chk("rnd_rob1", int'(src1_byp_rob_slot), m_rob[src1]);
      if (i == 1500) begin
        reset = 1'b1; #1;
        m_reset();
        chk("rnd_rst_s0", int'(src0_byp_mux_sel), 0);
        chk("rnd_rst_wb", int'(wb_mux_sel), 0);
        chk("rnd_rst_stall", int'(stall_hazard), int'(!m_accept()));
        @(posedge clk); #1; reset = 1'b0;
      end else begin
        advance();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
